// File: rtl/bcd2bin_conv.sv
// Sequential BCD-to-binary converter using reverse double-dabble:
// one right shift per cycle, then subtract 3 from every BCD nibble >= 8.
module bcd2bin_conv #(
    parameter int NDIG = 4,
    parameter int BW   = 14
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [4*NDIG-1:0]   bcd_i,
    output logic                busy,
    output logic                rdy,
    output logic                err,
    output logic [BW-1:0]       bin_o
);
    localparam int W  = 4 * NDIG;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_SHIFT, S_DONE} state_t;

    state_t          r_state, w_next;
    logic [W-1:0]    r_bcd, r_bin;
    logic [W-1:0]    w_bcd_sh, w_bcd_fix, w_bin_sh;
    logic [CW-1:0]   r_cnt;
    logic            r_busy, r_rdy, r_err;
    logic [BW-1:0]   r_bin_o;
    logic            w_bad, w_last;

    assign busy  = r_busy;
    assign rdy   = r_rdy;
    assign err   = r_err;
    assign bin_o = r_bin_o;

    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < NDIG; i++)
            if (r_bcd[4*i +: 4] > 4'd9) w_bad = 1'b1;
    end

    // The bit leaving the BCD register enters the top of the binary register.
    assign w_bcd_sh = r_bcd >> 1;
    assign w_bin_sh = {r_bcd[0], r_bin[W-1:1]};

    always_comb begin
        w_bcd_fix = w_bcd_sh;
        for (int i = 0; i < NDIG; i++)
            if (w_bcd_sh[4*i +: 4] >= 4'd8)
                w_bcd_fix[4*i +: 4] = w_bcd_sh[4*i +: 4] - 4'd3;
    end

    assign w_last = (r_cnt == CW'(W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (en) w_next = S_CHECK;
            S_CHECK: w_next = w_bad ? S_DONE : S_SHIFT;
            S_SHIFT: if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd   <= '0;
            r_bin   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_rdy   <= 1'b0;
            r_err   <= 1'b0;
            r_bin_o <= '0;
        end else begin
            r_rdy <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_bcd  <= bcd_i;
                        r_bin  <= '0;
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                    end
                end
                S_CHECK: begin
                    if (w_bad) begin
                        r_bin_o <= '0;
                        r_err   <= 1'b1;
                        r_rdy   <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    r_bcd <= w_bcd_fix;
                    r_bin <= w_bin_sh;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_bin_o <= w_bin_sh[BW-1:0];
                        r_err   <= 1'b0;
                        r_rdy   <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd2bin_conv.sv
// Directed plus randomized bench for bcd2bin_conv against a decimal-arithmetic model.
module tb_bcd2bin_conv;
    localparam int NDIG = 4;
    localparam int BW   = 14;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [4*NDIG-1:0] bcd_i;
    logic              busy, rdy, err;
    logic [BW-1:0]     bin_o;

    int n_cmp = 0;
    int n_err = 0;
    int prev_bin = 0;
    bit prev_err = 1'b0;

    bcd2bin_conv #(.NDIG(NDIG), .BW(BW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .bcd_i(bcd_i),
        .busy(busy), .rdy(rdy), .err(err), .bin_o(bin_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Decimal value of a packed BCD word; any digit above 9 makes it invalid.
    function automatic void model(input logic [4*NDIG-1:0] v, output int val, output bit bad);
        int d;
        val = 0;
        bad = 1'b0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            d = int'(v[4*i +: 4]);
            if (d > 9) bad = 1'b1;
            val = val * 10 + d;
        end
        if (bad) val = 0;
    endfunction

    task automatic start(input logic [4*NDIG-1:0] v);
        @(negedge clk);
        bcd_i = v;
        en    = 1'b1;
        @(posedge clk);
        #1;
        en    = 1'b0;
        bcd_i = ~v;
        chk("busy_after_E0", 32'(busy), 32'd1);
    endtask

    task automatic conv(input logic [4*NDIG-1:0] v, input int poke);
        int  exp_val, n;
        bit  exp_bad;
        bit  hold_ok;
        model(v, exp_val, exp_bad);
        start(v);
        n = 0;
        hold_ok = 1'b1;
        while (!rdy && n < 40) begin
            if (poke > 0 && n + 1 == poke) begin
                en    = 1'b1;
                bcd_i = 16'h1111;
            end
            @(posedge clk);
            #1;
            n++;
            en = 1'b0;
            if (!rdy && (busy !== 1'b1 || int'(bin_o) != prev_bin || err !== prev_err))
                hold_ok = 1'b0;
        end
        chk("busy_and_outputs_held", 32'(hold_ok), 32'd1);
        chk("latency", 32'(n), exp_bad ? 32'd1 : 32'(4*NDIG + 1));
        chk("bin_o", 32'(bin_o), 32'(exp_val));
        chk("err", 32'(err), 32'(exp_bad));
        chk("busy_at_rdy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("rdy_one_cycle", 32'(rdy), 32'd0);
        chk("bin_o_hold", 32'(bin_o), 32'(exp_val));
        if (poke > 0) begin
            @(posedge clk);
            #1;
            chk("no_second_rdy", 32'(rdy), 32'd0);
            chk("idle_not_busy", 32'(busy), 32'd0);
        end
        prev_bin = exp_val;
        prev_err = exp_bad;
    endtask

    initial begin
        int seen_rdy;
        logic [4*NDIG-1:0] v;

        rst_n = 1'b0;
        en    = 1'b0;
        bcd_i = '0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdy", 32'(rdy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_bin_o", 32'(bin_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        conv(16'h0000, 0);
        conv(16'h9999, 0);
        conv(16'h1234, 0);
        conv(16'h0010, 0);
        conv(16'h12A4, 0);
        conv(16'h0042, 0);
        conv(16'h0500, 5);

        // Abort mid-conversion with an asynchronous reset.
        start(16'h0777);
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rdy", 32'(rdy), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        chk("abort_bin_o", 32'(bin_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        prev_bin = 0;
        prev_err = 1'b0;
        seen_rdy = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (rdy === 1'b1 || busy === 1'b1) seen_rdy++;
        end
        chk("no_rdy_after_abort", 32'(seen_rdy), 32'd0);
        conv(16'h0777, 0);

        for (int k = 0; k < 24; k++) begin
            for (int d = 0; d < NDIG; d++)
                v[4*d +: 4] = 4'($urandom_range(0, 9));
            if (k % 4 == 3)
                v[4*$urandom_range(0, NDIG-1) +: 4] = 4'($urandom_range(10, 15));
            conv(v, (k % 5 == 2) ? int'($urandom_range(2, 15)) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
